onehot_pulse_decoder: RTL and testbench
=======================================

// Module: onehot_pulse_decoder
// PURPOSE
//  Drives a registered one-hot strobe from binary select codes (3 -> 8 by default).
//  Each accepted code drives exactly one output line high for PULSE_LEN cycles.
//  An optional idle gap of GAP_LEN all-zero cycles follows each pulse.
//  Pairs with the one-hot -> binary encoder: that block's binary output can feed this one.
//  A one-entry holding register queues the next code while a pulse is in flight.
// PARAMETERS
//  N_BITS     3   width of the binary select code; dec width = 2**N_BITS
//  PULSE_LEN  4   cycles each one-hot line is held high (legal: >= 1)
//  GAP_LEN    1   all-zero cycles after each pulse (legal: >= 0)
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  in_valid  in   1          bin is valid this cycle
//  in_ready  out  1          block can take a code; transfer when in_valid & in_ready at clk edge
//  bin       in   N_BITS     binary select code
//  dec       out  2**N_BITS  registered one-hot strobe (one line high, or all zero)
//  busy      out  1          high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, immediate) forces:
//   - dec = 0, busy = 0, in_ready = 1
//   - state = IDLE, hold_valid = 0, cnt = 0
//  The whole reset state applies even when rst_n falls mid-pulse; any queued code is discarded.
//  dec is always one-hot or zero (never more than one bit set).
//  in_ready = !hold_valid; it is registered-state derived, with no combinational path from in_valid.
//  States:
//   - IDLE:
//      - on accept: dec <= 1<<bin, cnt <= PULSE_LEN-1, go to DRIVE.
//      - latency from accept edge to dec valid is one cycle.
//   - DRIVE: dec held; cnt decrements each cycle. When cnt == 0:
//      - if GAP_LEN > 0: dec <= 0, cnt <= GAP_LEN-1, go to GAP.
//      - else if a next code is available: load it (dec <= 1<<code, cnt <= PULSE_LEN-1), stay in DRIVE.
//      - else: dec <= 0, go to IDLE.
//   - GAP: dec = 0; cnt decrements. When cnt == 0:
//      - if a next code is available: load it, go to DRIVE.
//      - else: go to IDLE.
//  "Next code" selection:
//   - The hold register takes priority if hold_valid.
//   - Otherwise a same-cycle accept bypasses the hold register and loads directly.
//   - A code loaded from hold clears hold_valid in the same edge.
//  While in DRIVE or GAP, an accept that is not consumed by the above writes the hold register and sets hold_valid.
//  Simultaneous consume of hold and new accept cannot occur (in_ready = 0 while hold is full).
//  bin is sampled only on an accept edge; changes to bin while in_valid = 0 are ignored.
//  cnt width = $clog2(max(PULSE_LEN, GAP_LEN) + 1); cnt never wraps (it reloads at 0).
//  PULSE_LEN = 1 gives single-cycle strobes. GAP_LEN = 0 gives back-to-back strobes with no zero cycle.
// STRUCTURE
//  Package onehot_pulse_pkg holds:
//   - state typedef enum {IDLE, DRIVE, GAP}
//   - localparam function for the cnt width
//  Sub-module bin_to_onehot (combinational, parameter N_BITS): out = 1 << in.
//   - Shared by dec load and hold-load paths; its output is registered in this block.
//  All outputs come from flops, except in_ready and busy, which are decoded from flops.
// TESTING (PULSE_LEN=4, GAP_LEN=1 unless stated)
//  1. Reset: hold rst_n = 0, then release -> dec = 8'h00, in_ready = 1, busy = 0.
//     Assert rst_n async between edges -> dec clears without a clock edge.
//  2. Single code: accept bin = 3'b101 at edge 0 -> dec = 8'h20 cycles 1-4, 8'h00 cycle 5,
//     busy = 1 cycles 1-5, busy = 0 cycle 6.
//  3. Back-to-back: accept 3'd0, then 3'd7 on the next edge -> dec sequence 8'h01 x4, 8'h00 x1, 8'h80 x4.
//     in_ready = 0 from the cycle after the second accept until 3'd7 loads.
//  4. Hold full: with a pulse running and hold full, present 3'd3 with in_valid = 1 -> in_ready = 0, no transfer.
//     When hold drains, 3'd3 is accepted once and later appears as 8'h08 for 4 cycles.
//  5. Reset mid-DRIVE: drop rst_n in cycle 2 of 8'h04 with a code held -> dec = 0 immediately.
//     After release, no residual pulse; the held code is lost.
//  6. GAP_LEN = 0, PULSE_LEN = 1: stream codes 0..7 with in_valid held high ->
//     dec = 8'h01, 02, 04, ... 80 on consecutive cycles.
//     Throughout, assert $onehot0(dec) every cycle.

Source files
------------

// File: rtl/onehot_pulse_pkg.sv
// Shared types and elaboration helpers for the one-hot pulse decoder.
//   state_t   : FSM state encoding (IDLE, DRIVE, GAP)
//   cnt_width : width of the cycle counter covering both pulse and gap lengths
package onehot_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter must hold max(pulse_len, gap_len) - 1; sized with one spare value.
  function automatic int unsigned cnt_width(input int unsigned pulse_len,
                                            input int unsigned gap_len);
    int unsigned longest;
    longest = (pulse_len > gap_len) ? pulse_len : gap_len;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/bin_to_onehot.sv
// Combinational binary to one-hot converter.
//   code   : binary select code (N_BITS)
//   onehot : 2**N_BITS wide vector with only bit [code] set
module bin_to_onehot #(
  parameter int unsigned N_BITS = 3
) (
  input  logic [N_BITS-1:0]      code,
  output logic [2**N_BITS-1:0]   onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Turns accepted binary codes into registered one-hot strobes of PULSE_LEN
// cycles, each followed by GAP_LEN all-zero cycles. One code can be queued
// in a holding register while a strobe or gap is in flight.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : bin is valid this cycle
//   in_ready   : a code can be taken (holding register empty)
//   bin        : binary select code
//   dec        : registered one-hot strobe (one line high or all zero)
//   busy       : FSM not idle
module onehot_pulse_decoder
  import onehot_pulse_pkg::*;
#(
  parameter int unsigned N_BITS    = 3,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     bin,
  output logic [2**N_BITS-1:0]  dec,
  output logic                  busy
);

  localparam int unsigned DEC_W = 2**N_BITS;
  localparam int unsigned CNT_W = cnt_width(PULSE_LEN, GAP_LEN);
  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

  state_t              state, state_nxt;
  logic [DEC_W-1:0]    dec_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                hold_valid, hold_valid_nxt;
  logic [N_BITS-1:0]   hold_code, hold_code_nxt;

  logic                accept;
  logic                have_next;
  logic                take_next;
  logic [N_BITS-1:0]   load_code;
  logic [DEC_W-1:0]    load_onehot;

  assign in_ready  = !hold_valid;
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign have_next = hold_valid | accept;

  // Held code has priority; otherwise a same-cycle accept bypasses the hold.
  assign load_code = hold_valid ? hold_code : bin;

  bin_to_onehot #(
    .N_BITS (N_BITS)
  ) u_bin_to_onehot (
    .code   (load_code),
    .onehot (load_onehot)
  );

  // State, strobe, counter and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dec        <= '0;
      cnt        <= '0;
      hold_valid <= 1'b0;
      hold_code  <= '0;
    end else begin
      state      <= state_nxt;
      dec        <= dec_nxt;
      cnt        <= cnt_nxt;
      hold_valid <= hold_valid_nxt;
      hold_code  <= hold_code_nxt;
    end
  end

  // Next-state, strobe sequencing and hold bookkeeping.
  always_comb begin
    state_nxt      = state;
    dec_nxt        = dec;
    cnt_nxt        = cnt;
    hold_valid_nxt = hold_valid;
    hold_code_nxt  = hold_code;
    take_next      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          dec_nxt   = load_onehot;
          cnt_nxt   = PULSE_RELOAD;
          state_nxt = DRIVE;
          take_next = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          if (GAP_LEN > 0) begin
            dec_nxt   = '0;
            cnt_nxt   = GAP_RELOAD;
            state_nxt = GAP;
          end else if (have_next) begin
            dec_nxt   = load_onehot;
            cnt_nxt   = PULSE_RELOAD;
            take_next = 1'b1;
          end else begin
            dec_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (have_next) begin
            dec_nxt   = load_onehot;
            cnt_nxt   = PULSE_RELOAD;
            state_nxt = DRIVE;
            take_next = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        dec_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    // An accept is never consumed alongside a full hold, since in_ready is low then.
    if (take_next && hold_valid) begin
      hold_valid_nxt = 1'b0;
    end else if (accept && !take_next) begin
      hold_valid_nxt = 1'b1;
      hold_code_nxt  = bin;
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: default instance (4/1) and a
// PULSE_LEN=1, GAP_LEN=0 instance for streaming.
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2;
  logic [2:0] bin, bin2;
  logic [7:0] dec, dec2;
  logic       busy, busy2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.N_BITS(3), .PULSE_LEN(4), .GAP_LEN(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin      (bin),
    .dec      (dec),
    .busy     (busy)
  );

  onehot_pulse_decoder #(.N_BITS(3), .PULSE_LEN(1), .GAP_LEN(0)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .bin      (bin2),
    .dec      (dec2),
    .busy     (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dec must never have more than one line set.
  always @(negedge clk) begin
    check("onehot0_dec",  32'($onehot0(dec)),  32'd1);
    check("onehot0_dec2", 32'($onehot0(dec2)), 32'd1);
  end

  logic [7:0] exp3_dec [11]  = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                                 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
  logic       exp3_rdy [11]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] exp4_dec [16]  = '{8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00,
                                 8'h04, 8'h04, 8'h04, 8'h04, 8'h00,
                                 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
  logic       exp4_rdy [16]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] exp6_dec [8]   = '{8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    bin       = 3'd0;
    in_valid2 = 1'b0;
    bin2      = 3'd0;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, during and after reset
    check("rst_dec",      32'(dec),      32'h00);
    check("rst_ready",    32'(in_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_dec",      32'(dec),      32'h00);
    check("rel_ready",    32'(in_ready), 32'd1);
    check("rel_busy",     32'(busy),     32'd0);
    check("rel_dec2",     32'(dec2),     32'h00);

    // Single code 5
    bin = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("t2_dec_c%0d", c),  32'(dec),  (c <= 4) ? 32'h20 : 32'h00);
      check($sformatf("t2_busy_c%0d", c), 32'(busy), (c <= 5) ? 32'd1 : 32'd0);
      tick();
    end

    // Back-to-back: 0 then 7
    bin = 3'd0; in_valid = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("t3_dec_c%0d", c),   32'(dec),      32'(exp3_dec[c]));
      check($sformatf("t3_ready_c%0d", c), 32'(in_ready), 32'(exp3_rdy[c]));
      if (c == 1) bin = 3'd7;
      tick();
      if (c == 1) in_valid = 1'b0;
    end
    check("t3_idle_busy", 32'(busy), 32'd0);

    // Hold full: 1, 2 queued, 3 stalled until hold drains
    bin = 3'd1; in_valid = 1'b1;
    tick();
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("t4_dec_c%0d", c),   32'(dec),      32'(exp4_dec[c]));
      check($sformatf("t4_ready_c%0d", c), 32'(in_ready), 32'(exp4_rdy[c]));
      if (c == 1) bin = 3'd2;
      if (c == 2) bin = 3'd3;
      tick();
      if (c == 6) in_valid = 1'b0;
    end
    check("t4_idle_busy",  32'(busy),     32'd0);
    check("t4_idle_ready", 32'(in_ready), 32'd1);
    check("t4_idle_dec",   32'(dec),      32'h00);

    // Reset mid-DRIVE with a code held
    bin = 3'd2; in_valid = 1'b1;
    tick();
    bin = 3'd6;
    tick();
    in_valid = 1'b0;
    check("t5_pre_dec",   32'(dec),      32'h04);
    check("t5_pre_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_dec",   32'(dec),      32'h00);
    check("t5_async_busy",  32'(busy),     32'd0);
    check("t5_async_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("t5_post_dec_c%0d", c),  32'(dec),  32'h00);
      check($sformatf("t5_post_busy_c%0d", c), 32'(busy), 32'd0);
    end

    // Streaming on the PULSE_LEN=1, GAP_LEN=0 instance
    bin2 = 3'd0; in_valid2 = 1'b1;
    tick();
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("t6_dec_%0d", i - 1),   32'(dec2),      32'(exp6_dec[i-1]));
      check($sformatf("t6_ready_%0d", i - 1), 32'(in_ready2), 32'd1);
      bin2 = 3'(i);
      tick();
    end
    in_valid2 = 1'b0;
    check("t6_dec_7",  32'(dec2),  32'h80);
    check("t6_busy_7", 32'(busy2), 32'd1);
    tick();
    check("t6_end_dec",  32'(dec2),  32'h00);
    check("t6_end_busy", 32'(busy2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
